// File: rtl/cbfp1_denorm.sv
// cbfp1_denorm: block-floating-point de-normaliser for the CBFP1 FFT stage.
// Buffers per-block shift exponents in a FIFO, pairs each data beat with one
// entry, pre-scales the <6.6> mantissas, and rounds back to a common scale.
// Optional feature macro: CBFP1_DENORM_SAT_EN (saturate instead of wrap).

// One real sample: t = x * 2^L_SHIFT, round-half-up shift by e, then saturate or wrap.
module cbfp1_denorm_lane #(
    parameter int IN_W    = 12,
    parameter int OUT_W   = 16,
    parameter int EXP_W   = 5,
    parameter int MAX_EXP = 20,
    parameter int L_SHIFT = 5
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    en,
    input  logic signed [IN_W-1:0]  x,
    input  logic [EXP_W-1:0]        e,
    output logic [OUT_W-1:0]        y,
    output logic                    sat
);
    // Wide enough for the pre-scaled sample plus the largest rounding constant.
    localparam int TW = (((IN_W + L_SHIFT) > MAX_EXP) ? (IN_W + L_SHIFT) : MAX_EXP) + 2;

    logic signed [TW-1:0] t, rnd, shr;
    logic [OUT_W-1:0]     y_c;

    assign t   = TW'(x) <<< L_SHIFT;
    assign rnd = (e == '0) ? '0 : (TW'(1) <<< (e - 1'b1));
    assign shr = (t + rnd) >>> e;

`ifdef CBFP1_DENORM_SAT_EN
    localparam logic signed [TW-1:0] SAT_HI = TW'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [TW-1:0] SAT_LO = ~SAT_HI;

    // Clamp to the signed output range and report the clamp.
    always_comb begin
        sat = 1'b0;
        y_c = shr[OUT_W-1:0];
        if (shr > SAT_HI) begin
            y_c = SAT_HI[OUT_W-1:0];
            sat = 1'b1;
        end else if (shr < SAT_LO) begin
            y_c = SAT_LO[OUT_W-1:0];
            sat = 1'b1;
        end
    end
`else
    logic unused_hi;
    assign unused_hi = ^shr[TW-1:OUT_W];

    // Two's-complement wrap: keep the low OUT_W bits.
    always_comb begin
        sat = 1'b0;
        y_c = shr[OUT_W-1:0];
    end
`endif

    // S2 output register; holds its value between valid beats.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)   y <= '0;
        else if (en) y <= y_c;
    end
endmodule

module cbfp1_denorm #(
    parameter int IN_W       = 12,
    parameter int OUT_W      = 16,
    parameter int NCHAN      = 16,
    parameter int BLOCK_SIZE = 8,
    parameter int NBLOCKS    = NCHAN / BLOCK_SIZE,
    parameter int EXP_W      = 5,
    parameter int MAX_EXP    = 20,
    parameter int L_SHIFT    = 5,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              exp_valid,
    input  logic [NBLOCKS-1:0][EXP_W-1:0]     exp_in,
    output logic                              exp_ready,
    input  logic                              data_valid_in,
    input  logic [NCHAN-1:0][IN_W-1:0]        data_re_in,
    input  logic [NCHAN-1:0][IN_W-1:0]        data_im_in,
    output logic [NCHAN-1:0][OUT_W-1:0]       data_re_out,
    output logic [NCHAN-1:0][OUT_W-1:0]       data_im_out,
    output logic                              valid_out,
    output logic                              sat_flag,
    output logic                              err_underflow,
    output logic                              err_overflow,
    output logic                              err_range
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int STAGES = 2;

    logic [NBLOCKS-1:0][EXP_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]              wr_ptr, rd_ptr;
    logic [CNT_W-1:0]              count;
    logic                          push, pop, empty, range_hit;
    logic [NBLOCKS-1:0][EXP_W-1:0] exp_pop;

    logic [NCHAN-1:0][IN_W-1:0]    re_s1, im_s1;
    logic [NBLOCKS-1:0][EXP_W-1:0] exp_s1;
    logic [STAGES:1]               vld_pipe;
    logic [NCHAN-1:0]              sat_re, sat_im;

    assign exp_ready = (count != CNT_W'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign push      = exp_valid && exp_ready;
    assign pop       = data_valid_in && !empty;
    assign valid_out = vld_pipe[STAGES];

    // Exponent storage; contents need no reset, the count guards them.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= exp_in;
    end

    // FIFO pointers and occupancy; a beat on an empty FIFO does not pop.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Head entry, forced to zero when empty and clamped to MAX_EXP.
    always_comb begin
        range_hit = 1'b0;
        exp_pop   = '0;
        for (int b = 0; b < NBLOCKS; b++) begin
            if (!empty) begin
                if (mem[rd_ptr][b] > EXP_W'(MAX_EXP)) begin
                    exp_pop[b] = EXP_W'(MAX_EXP);
                    range_hit  = range_hit | data_valid_in;
                end else begin
                    exp_pop[b] = mem[rd_ptr][b];
                end
            end
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_underflow <= 1'b0;
            err_overflow  <= 1'b0;
            err_range     <= 1'b0;
        end else begin
            err_underflow <= err_underflow | (data_valid_in & empty);
            err_overflow  <= err_overflow  | (exp_valid & ~exp_ready);
            err_range     <= err_range     | range_hit;
        end
    end

    // S1: capture mantissas and paired exponents; valid shift register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            re_s1    <= '0;
            im_s1    <= '0;
            exp_s1   <= '0;
            vld_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], data_valid_in};
            if (data_valid_in) begin
                re_s1  <= data_re_in;
                im_s1  <= data_im_in;
                exp_s1 <= exp_pop;
            end
        end
    end

    // S2 per-sample arithmetic; sample i belongs to block i / BLOCK_SIZE.
    for (genvar i = 0; i < NCHAN; i++) begin : g_lane
        localparam int BLK = i / BLOCK_SIZE;
        cbfp1_denorm_lane #(
            .IN_W(IN_W), .OUT_W(OUT_W), .EXP_W(EXP_W),
            .MAX_EXP(MAX_EXP), .L_SHIFT(L_SHIFT)
        ) u_re (
            .clk(clk), .rstn(rstn), .en(vld_pipe[1]),
            .x(re_s1[i]), .e(exp_s1[BLK]), .y(data_re_out[i]), .sat(sat_re[i])
        );
        cbfp1_denorm_lane #(
            .IN_W(IN_W), .OUT_W(OUT_W), .EXP_W(EXP_W),
            .MAX_EXP(MAX_EXP), .L_SHIFT(L_SHIFT)
        ) u_im (
            .clk(clk), .rstn(rstn), .en(vld_pipe[1]),
            .x(im_s1[i]), .e(exp_s1[BLK]), .y(data_im_out[i]), .sat(sat_im[i])
        );
    end

    // S2 beat-level saturation flag (lanes report 0 in the wrapping build).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)            sat_flag <= 1'b0;
        else if (vld_pipe[1]) sat_flag <= |{sat_re, sat_im};
    end
endmodule

// File: tb/tb_cbfp1_denorm.sv
// Bench for cbfp1_denorm: directed vectors, a queue-based reference model
// checked every cycle, and literal expectations for the documented scenarios.
module tb_cbfp1_denorm;
    localparam int NCHAN = 16, IN_W = 12, OUT_W = 16, EXP_W = 5, NB = 2;

    logic clk = 1'b0, rstn = 1'b1;
    logic exp_valid = 1'b0, data_valid_in = 1'b0;
    logic [NB-1:0][EXP_W-1:0]     exp_in = '0;
    logic [NCHAN-1:0][IN_W-1:0]   data_re_in = '0, data_im_in = '0;
    logic [NCHAN-1:0][OUT_W-1:0]  data_re_out, data_im_out;
    logic exp_ready, valid_out, sat_flag, err_underflow, err_overflow, err_range;

    always #5 clk = ~clk;

    cbfp1_denorm dut (
        .clk(clk), .rstn(rstn), .exp_valid(exp_valid), .exp_in(exp_in),
        .exp_ready(exp_ready), .data_valid_in(data_valid_in),
        .data_re_in(data_re_in), .data_im_in(data_im_in),
        .data_re_out(data_re_out), .data_im_out(data_im_out),
        .valid_out(valid_out), .sat_flag(sat_flag),
        .err_underflow(err_underflow), .err_overflow(err_overflow), .err_range(err_range)
    );

    int n_tests = 0, n_fail = 0, cyc = 0;

    typedef logic [NB-1:0][EXP_W-1:0] ent_t;
    typedef struct {
        logic [NCHAN-1:0][OUT_W-1:0] re;
        logic [NCHAN-1:0][OUT_W-1:0] im;
        bit sat;
        int due;
    } beat_t;

    ent_t  fq[$];
    beat_t pend[$];
    bit m_uf = 0, m_ov = 0, m_rg = 0;
    logic [NCHAN-1:0][OUT_W-1:0] last_re = '0, last_im = '0;

    task automatic chk(string nm, longint act, longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chkv(string nm, logic [NCHAN*OUT_W-1:0] act, logic [NCHAN*OUT_W-1:0] exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: y = round_half_up(x*32 / 2^e), then saturate or wrap.
    function automatic logic [OUT_W-1:0] ref_val(int x, int e, inout bit s);
        longint t, y;
        t = longint'(x) * 32;
        if (e > 0) y = (t + (longint'(1) << (e - 1))) >>> e;
        else       y = t;
`ifdef CBFP1_DENORM_SAT_EN
        if (y > 32767)       begin y = 32767;  s = 1; end
        else if (y < -32768) begin y = -32768; s = 1; end
`endif
        return y[OUT_W-1:0];
    endfunction

    // Model: FIFO as a queue, each beat produces an expected output one edge later.
    always @(posedge clk) begin : model
        bit    full, s;
        ent_t  e;
        beat_t b;
        if (rstn) begin
            cyc++;
            full = (fq.size() == 16);
            if (data_valid_in) begin
                if (fq.size() == 0) begin e = '0; m_uf = 1; end
                else e = fq.pop_front();
                for (int k = 0; k < NB; k++)
                    if (e[k] > 20) begin e[k] = 5'd20; m_rg = 1; end
                s = 0;
                for (int i = 0; i < NCHAN; i++) begin
                    b.re[i] = ref_val($signed(data_re_in[i]), int'(e[i/8]), s);
                    b.im[i] = ref_val($signed(data_im_in[i]), int'(e[i/8]), s);
                end
                b.sat = s;
                b.due = cyc + 1;
                pend.push_back(b);
            end
            if (exp_valid) begin
                if (full) m_ov = 1;
                else      fq.push_back(exp_in);
            end
        end
    end

    always @(negedge rstn) begin
        fq.delete();
        pend.delete();
        m_uf = 0; m_ov = 0; m_rg = 0;
        last_re = '0; last_im = '0;
    end

    // Compare process: every cycle, outputs against the model.
    always @(negedge clk) begin : compare
        bit    ev;
        beat_t b;
        while (pend.size() > 0 && pend[0].due < cyc) begin
            void'(pend.pop_front());
            chk("stale beat", 1, 0);
        end
        ev = (pend.size() > 0) && (pend[0].due == cyc);
        chk("valid_out", longint'(valid_out), longint'(ev));
        if (ev) begin
            b = pend.pop_front();
            chkv("re beat", data_re_out, b.re);
            chkv("im beat", data_im_out, b.im);
            chk("sat_flag", longint'(sat_flag), longint'(b.sat));
            last_re = b.re;
            last_im = b.im;
        end else begin
            chkv("re hold", data_re_out, last_re);
            chkv("im hold", data_im_out, last_im);
        end
        chk("exp_ready", longint'(exp_ready), longint'(fq.size() != 16));
        chk("err_underflow", longint'(err_underflow), longint'(m_uf));
        chk("err_overflow", longint'(err_overflow), longint'(m_ov));
        chk("err_range", longint'(err_range), longint'(m_rg));
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_beat(int re_v, int im_v);
        for (int i = 0; i < NCHAN; i++) begin
            data_re_in[i] = IN_W'(re_v);
            data_im_in[i] = IN_W'(im_v);
        end
    endtask

    task automatic push_exp(int e0, int e1);
        exp_valid = 1'b1;
        exp_in[0] = EXP_W'(e0);
        exp_in[1] = EXP_W'(e1);
    endtask

    initial begin : stim
        int vcnt;
        #1 rstn = 1'b0;
        repeat (3) step();
        chk("reset valid_out", longint'(valid_out), 0);
        chk("reset exp_ready", longint'(exp_ready), 1);
        chk("reset re0", $signed(data_re_out[0]), 0);
        rstn = 1'b1;
        step();

        // Basic scaling
        push_exp(2, 6); step();
        exp_valid = 0; set_beat(100, 3); data_valid_in = 1; step();
        data_valid_in = 0; step();
        chk("basic re0", $signed(data_re_out[0]), 800);
        chk("basic im0", $signed(data_im_out[0]), 24);
        chk("basic re8", $signed(data_re_out[8]), 50);
        chk("basic im8", $signed(data_im_out[8]), 2);

        // Rounding and saturation / wrap
        push_exp(0, 6); step();
        exp_valid = 0; set_beat(0, 0);
        data_re_in[0] = 12'd2047; data_re_in[1] = 12'h800; data_re_in[8] = 12'hffd;
        data_valid_in = 1; step();
        data_valid_in = 0; step();
`ifdef CBFP1_DENORM_SAT_EN
        chk("sat re0", $signed(data_re_out[0]), 32767);
        chk("sat re1", $signed(data_re_out[1]), -32768);
        chk("sat flag", longint'(sat_flag), 1);
`else
        chk("wrap re0", $signed(data_re_out[0]), -32);
        chk("wrap re1", $signed(data_re_out[1]), 0);
        chk("wrap flag", longint'(sat_flag), 0);
`endif
        chk("round re8", $signed(data_re_out[8]), -1);

        // FIFO fill, overflow and ordering
        for (int k = 0; k < 16; k++) begin push_exp(k, k); step(); end
        chk("full exp_ready", longint'(exp_ready), 0);
        push_exp(31, 31); step();
        exp_valid = 0;
        chk("overflow flag", longint'(err_overflow), 1);
        set_beat(1, 1);
        for (int k = 0; k < 16; k++) begin
            data_valid_in = 1; step();
            if (k == 1) chk("order e0", $signed(data_re_out[0]), 32);
            if (k == 2) chk("order e1", $signed(data_re_out[0]), 16);
            if (k == 7) chk("order e6", $signed(data_re_out[0]), 1);
            if (k == 8) chk("order e7", $signed(data_re_out[0]), 0);
        end
        data_valid_in = 0; step(); step();
        chk("drained exp_ready", longint'(exp_ready), 1);

        // Exponent range clamp
        chk("range before", longint'(err_range), 0);
        push_exp(25, 3); step();
        exp_valid = 0; set_beat(100, 0); data_valid_in = 1; step();
        data_valid_in = 0; step();
        chk("range flag", longint'(err_range), 1);
        chk("range re0", $signed(data_re_out[0]), 0);
        chk("range re8", $signed(data_re_out[8]), 400);

        // Underflow with simultaneous push
        chk("underflow before", longint'(err_underflow), 0);
        push_exp(3, 3); set_beat(64, 64); data_valid_in = 1; step();
        exp_valid = 0; set_beat(64, 0); step();
        data_valid_in = 0;
        chk("underflow re0", $signed(data_re_out[0]), 2048);
        chk("underflow flag", longint'(err_underflow), 1);
        step();
        chk("after underflow re0", $signed(data_re_out[0]), 256);

        // Back-to-back streaming with count held at 1
        push_exp(1, 2); step();
        vcnt = 0;
        for (int i = 0; i < 8; i++) begin
            push_exp(i, 7 - i);
            for (int j = 0; j < NCHAN; j++) begin
                data_re_in[j] = IN_W'(j * 37 - 200 + i * 11);
                data_im_in[j] = IN_W'(i - j * 13);
            end
            data_valid_in = 1; step();
            vcnt += int'(valid_out);
        end
        exp_valid = 0; data_valid_in = 0;
        repeat (4) begin step(); vcnt += int'(valid_out); end
        chk("stream valid count", vcnt, 8);
        set_beat(5, 5); data_valid_in = 1; step();
        data_valid_in = 0; step(); step();

        // Reset mid-stream: count 5, two beats in flight
        for (int k = 0; k < 7; k++) begin push_exp(2, 2); step(); end
        exp_valid = 0; set_beat(10, 10); data_valid_in = 1; step();
        set_beat(20, 20);
        @(posedge clk);
        #2 data_valid_in = 0; rstn = 1'b0;
        #1;
        chk("midreset valid_out", longint'(valid_out), 0);
        chk("midreset re0", $signed(data_re_out[0]), 0);
        chk("midreset exp_ready", longint'(exp_ready), 1);
        chk("midreset overflow", longint'(err_overflow), 0);
        step();
        rstn = 1'b1;
        repeat (3) begin step(); chk("post-reset quiet", longint'(valid_out), 0); end
        push_exp(0, 0); step();
        exp_valid = 0; set_beat(7, -7); data_valid_in = 1; step();
        data_valid_in = 0; step();
        chk("post-reset re0", $signed(data_re_out[0]), 224);
        chk("post-reset im0", $signed(data_im_out[0]), -224);
        repeat (2) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cbfp1_denorm.md
# cbfp1_denorm

Block-floating-point de-normaliser paired with the CBFP1 stage of the FFT pipeline. It takes the 12-bit `<6.6>` normalised mantissas, 16 samples per clock in two 8-sample blocks, and restores a common fixed-point scale. Each block's shift exponent is issued by the CBFP side ahead of the data, so the exponents are buffered in an internal FIFO and paired in order with data beats. It sits at the FFT output, ahead of result formatting.

## Interface
- `IN_W`, 12, mantissa width (signed).
- `OUT_W`, 16, output width (signed).
- `NCHAN`, 16, samples per beat.
- `BLOCK_SIZE`, 8, samples per exponent block.
- `NBLOCKS`, `NCHAN/BLOCK_SIZE` (2), exponents per beat.
- `EXP_W`, 5, exponent width (unsigned).
- `MAX_EXP`, 20, largest legal exponent.
- `L_SHIFT`, 5, fixed pre-scale applied before the exponent shift.
- `FIFO_DEPTH`, 16, exponent entries (power of two); one entry holds `NBLOCKS` exponents.

Ports:
- `clk` in 1: clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `exp_valid` in 1: exponent entry offered.
- `exp_in[0:NBLOCKS-1]` in `EXP_W`: per-block exponents, block 0 = samples 0..7.
- `exp_ready` out 1: FIFO can accept an entry.
- `data_valid_in` in 1: mantissa beat valid.
- `data_re_in[0:NCHAN-1]`, `data_im_in[0:NCHAN-1]` in `IN_W`: mantissas.
- `data_re_out[0:NCHAN-1]`, `data_im_out[0:NCHAN-1]` out `OUT_W`: de-normalised samples.
- `valid_out` out 1: output beat valid.
- `sat_flag` out 1: at least one of the 32 outputs in this beat saturated.
- `err_underflow` out 1: sticky; data arrived with the FIFO empty.
- `err_overflow` out 1: sticky; `exp_valid` offered while `exp_ready` was 0.
- `err_range` out 1: sticky; an exponent above `MAX_EXP` was popped.

## Operation
- **Exponent FIFO**
  - Circular buffer with read/write pointers and a count.
  - `exp_ready = (count != FIFO_DEPTH)`, combinational from registered count.
  - Push when `exp_valid && exp_ready`.
  - `exp_valid && !exp_ready`: entry is dropped and `err_overflow` is set.
- **Pairing**
  - Each `data_valid_in` pops exactly one entry.
  - Block b (samples b·8..b·8+7, re and im) uses `exp_in[b]` of that entry.
- **Empty FIFO**
  - Pop with count 0: exponents are forced to 0 and `err_underflow` is set.
  - No bypass. A push in the same cycle is stored and serves the next beat.
- **Simultaneous push and pop**: count is unchanged; both pointers advance.
- **Exponent range**: an exponent above `MAX_EXP` is clamped to `MAX_EXP` and `err_range` is set.
- **Arithmetic, per sample x with exponent e**
  - t = sign_extend(x) · 2^`L_SHIFT`, held at full width (`IN_W+L_SHIFT+1` bits minimum).
  - If e > 0: y = (t + 2^(e-1)) >>> e. This is round-half-up toward +∞.
  - If e = 0: y = t.
  - y is saturated to the `OUT_W` signed range (see Configuration).
- **Error flags**: the `err_*` flags clear only on reset.

## Timing
- **Pipeline, two register stages**
  - S1 registers the mantissas, the popped and clamped exponents, and the valid bit.
  - S2 registers the rounded and saturated result, `valid_out` and `sat_flag`.
- **Latency**: `data_valid_in` at cycle n gives `valid_out` at cycle n+2.
- **Throughput**: one beat per clock. There is no stall and no backpressure on the data path.
- **Output hold**: outputs hold their last value while `valid_out` is 0. `sat_flag` is meaningful only when `valid_out` = 1.
- **FIFO visibility**: an exponent pushed at cycle n can be popped by data at cycle n+1 or later.
- **Reset (asynchronous, `rstn` = 0)**
  - All data outputs, `valid_out`, `sat_flag` and `err_*` go to 0.
  - FIFO pointers and count go to 0, so `exp_ready` = 1.
  - In-flight beats are discarded and no `valid_out` is produced for them.

## Configuration
- **`CBFP1_DENORM_SAT_EN` defined**: y is clamped to [-2^(`OUT_W`-1), 2^(`OUT_W`-1)-1]. `sat_flag` is asserted when any sample in the beat clamped.
- **Not defined**:
  - y is truncated to its low `OUT_W` bits, i.e. two's-complement wrap.
  - `sat_flag` is tied to 0.

## Test plan
- **Basic scaling**: push {2,6}, then one beat with all re = 100 and all im = 3 → after 2 cycles:
  - block 0: re = 800, im = 24;
  - block 1: re = 50, im = 2 (96/64 = 1.5 rounds to 2).
- **Rounding and saturation** (SAT_EN defined): push {0,6}, beat with sample 0 re = 2047, sample 1 re = -2048, sample 8 re = -3 → re0 = 32767, re1 = -32768, re8 = -1, `sat_flag` = 1. Without the macro: re0 = -32, re1 = 0, `sat_flag` = 0.
- **FIFO fill and ordering**:
  - Push 16 entries with exponents k = 0..15; `exp_ready` must drop after the 16th.
  - A 17th offer sets `err_overflow`.
  - 16 beats of re = 1 → outputs 32 >> k with rounding, in push order.
- **Underflow**: data beat with the FIFO empty and a simultaneous push of {3,3}, re = 64:
  - That beat outputs 2048 (exponent 0) and `err_underflow` = 1.
  - The next beat pairs with {3,3} and outputs 256.
- **Back-to-back streaming**: 8 consecutive beats with interleaved single pushes and count at 1 → `valid_out` high for exactly 8 consecutive cycles starting at n+2, count unchanged.
- **Reset mid-stream**:
  - Assert `rstn` = 0 with 2 beats in flight and count = 5 → all outputs are 0 immediately and `exp_ready` = 1.
  - After release there is no `valid_out` until new data arrives.
